whack_mole_ctrl: RTL and testbench
==================================

# whack_mole_ctrl

Game controller for the whack-a-mole board. It sits directly downstream of the per-key debounce/edge-detect stage and the tick generator, and consumes one-cycle key-press pulses, a periodic tick and a pause level. It lights one of four mole LEDs at pseudo-random positions, scores correct hits, counts misses and ends the game after a miss limit. The board top instantiates it in place of the single-LED blink logic.

## Interface
- UP_TICKS, 750: ticks a mole stays lit; must be ≥1.
- GAP_TICKS, 250: dark ticks between moles; must be ≥1.
- FLASH_TICKS, 200: ticks `hit_led` is held after a successful hit; must be ≥1.
- MAX_MISSES, 3: miss count that ends the game; range 1..15.
- LFSR_SEED, 16'hACE1: LFSR reset value; a value of 0 is replaced by 16'h0001.
- clk  in  1  system clock (50 MHz on board).
- rst_n  in  1  asynchronous, active-low reset.
- tick  in  1  one-cycle timebase pulse (1 kHz on board).
- start  in  1  one-cycle pulse that starts a game.
- paused  in  1  level; while high, timers freeze and hits are ignored.
- hit  in  4  one-cycle press pulses, one bit per key/mole.
- mole_led  out  4  one-hot lit mole, or 0.
- hit_led  out  1  high during the hit flash.
- score  out  8  successful hits; saturates at 255.
- miss_cnt  out  4  misses in the current game.
- game_over  out  1  high in OVER.

## Operation
- States are IDLE, GAP, UP, FLASH and OVER.
- `timer` semantics: a phase loads N on entry. It decrements on `tick & ~paused` and exits on the tick where `timer == 1`, so each phase lasts exactly N unpaused ticks.
- IDLE: all outputs 0. `start` clears score and miss_cnt, loads GAP_TICKS and moves to GAP.
- GAP: at expiry, latch `idx = lfsr[1:0]`, set `mole_led = 1 << idx`, load UP_TICKS and move to UP.
- UP, hit: `hit[idx]` set with `~paused` increments score (saturating), clears mole_led, sets hit_led, loads FLASH_TICKS and moves to FLASH. Extra wrong bits in the same vector are ignored.
- UP, miss: a nonzero `hit` without bit idx, or timer expiry with no hit, increments miss_cnt and clears mole_led.
  - If the new miss_cnt equals MAX_MISSES, go to OVER.
  - Otherwise load GAP_TICKS and go to GAP.
- UP, simultaneous events: a correct hit and expiry in the same cycle count as a hit.
- FLASH: at expiry, clear hit_led, load GAP_TICKS and go to GAP.
- OVER: game_over=1, mole_led=0, and score/miss_cnt are held. `start` restarts exactly as from IDLE.
- `start` is ignored in GAP, UP and FLASH. `hit` is ignored outside UP.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1. It advances every clk cycle regardless of state or pause, so position depends on the player's timing.

## Timing
- All outputs are registered. Effects appear the cycle after the causing input edge, with no combinational path from inputs to outputs.
- Reset (async assert, sync-safe deassert): state=IDLE, timer=0, all outputs 0, lfsr=LFSR_SEED (or 1).
- Reset mid-game returns to IDLE immediately. Nothing survives reset.
- `paused` asserted in UP/GAP/FLASH freezes the timer at its current value. A tick coincident with `paused` is not counted.
- Timer width is $clog2 of the largest of UP_TICKS, GAP_TICKS and FLASH_TICKS, plus 1.
- Score saturation: at 255, a further hit keeps 255 but still enters FLASH.

## Structure
- Shared header `whack_defs.vh` holds the state encodings (3-bit), `N_MOLES = 4` and the LFSR tap constant. The debounce/top logic reuses `N_MOLES`.
- One sub-module, `lfsr16`, with ports clk, rst_n, seed, and q[15:0]. Its output is free-running.
- The FSM, timer and counters live in `whack_mole_ctrl`.

## Test plan
All scenarios use UP_TICKS=4, GAP_TICKS=2, FLASH_TICKS=1, MAX_MISSES=3, and tick every 4 clk.
- Reset, then `start`: GAP for exactly 2 ticks, then mole_led one-hot equal to `1 << lfsr[1:0]` sampled at the expiry cycle. score=0, miss_cnt=0.
- Correct hit in UP: score=1, hit_led=1 for 1 tick, then GAP. A 4-bit `hit` of all ones on the lit mole also scores 1.
- Wrong key, then timeout, then timeout: miss_cnt goes 1, 2, 3. game_over=1 and mole_led=0 after the third. A second `start` clears score and miss_cnt.
- Correct hit on the same cycle as the final UP tick: scored as a hit, miss_cnt unchanged.
- `paused` held for 20 ticks mid-UP: mole_led unchanged, hits ignored. UP completes 4 total unpaused ticks after release.
- `rst_n` pulsed low mid-FLASH: all outputs 0 asynchronously, state IDLE. After release, `start` behaves as the first scenario. Preload score=255 then hit: score stays 255.

Source files
------------

// File: rtl/whack_mole_ctrl_pkg.sv
// Shared definitions for the whack-a-mole game controller: FSM state
// encodings, mole count, LFSR feedback mask and a constant helper used to
// size the phase timer.
package whack_mole_ctrl_pkg;

   localparam int unsigned N_MOLES  = 4;
   localparam int unsigned LFSR_W   = 16;

   // Right-shifting Galois mask for x^16 + x^14 + x^13 + x^11 + 1
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

   localparam int unsigned SCORE_W = 8;
   localparam int unsigned MISS_W  = 4;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_GAP   = 3'd1,
      ST_UP    = 3'd2,
      ST_FLASH = 3'd3,
      ST_OVER  = 3'd4
   } state_e;

   // Largest of three phase lengths; sizes the shared timer
   function automatic int unsigned max3(input int unsigned a,
                                        input int unsigned b,
                                        input int unsigned c);
      int unsigned m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      return m;
   endfunction

endpackage

// File: rtl/whack_mole_ctrl_lfsr16.sv
// Free-running 16-bit Galois LFSR.
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset, loads seed (0 replaced by 1)
//   seed  - reset value
//   q     - current LFSR state, advances every cycle
module lfsr16
   import whack_mole_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [LFSR_W-1:0] seed,
   output logic [LFSR_W-1:0] q
);

   logic [LFSR_W-1:0] lfsr_q;
   logic [LFSR_W-1:0] lfsr_d;
   logic [LFSR_W-1:0] seed_safe;

   // An all-zero state would lock up the register
   assign seed_safe = (seed == '0) ? LFSR_W'(1) : seed;

   always_comb begin
      lfsr_d = {1'b0, lfsr_q[LFSR_W-1:1]};
      if (lfsr_q[0]) lfsr_d = lfsr_d ^ LFSR_TAPS;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) lfsr_q <= seed_safe;
      else        lfsr_q <= lfsr_d;
   end

   assign q = lfsr_q;

endmodule

// File: rtl/whack_mole_ctrl.sv
// Whack-a-mole game controller: lights one of four moles at pseudo-random
// positions, scores correct hits, counts misses and ends the game after
// MAX_MISSES misses. All outputs are registered.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   tick       - one-cycle timebase pulse
//   start      - one-cycle pulse, starts a game from IDLE or OVER
//   paused     - level, freezes timers and masks hits
//   hit[3:0]   - one-cycle key-press pulses, one per mole
//   mole_led   - one-hot lit mole or 0
//   hit_led    - high during the post-hit flash
//   score      - successful hits, saturating at 255
//   miss_cnt   - misses in the current game
//   game_over  - high in OVER
module whack_mole_ctrl
   import whack_mole_ctrl_pkg::*;
#(
   parameter int unsigned       UP_TICKS    = 750,
   parameter int unsigned       GAP_TICKS   = 250,
   parameter int unsigned       FLASH_TICKS = 200,
   parameter int unsigned       MAX_MISSES  = 3,
   parameter logic [LFSR_W-1:0] LFSR_SEED   = 16'hACE1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               tick,
   input  logic               start,
   input  logic               paused,
   input  logic [N_MOLES-1:0] hit,
   output logic [N_MOLES-1:0] mole_led,
   output logic               hit_led,
   output logic [SCORE_W-1:0] score,
   output logic [MISS_W-1:0]  miss_cnt,
   output logic               game_over
);

   localparam int unsigned TIMER_W =
      $clog2(max3(UP_TICKS, GAP_TICKS, FLASH_TICKS)) + 1;

   localparam logic [TIMER_W-1:0] UP_LOAD    = TIMER_W'(UP_TICKS);
   localparam logic [TIMER_W-1:0] GAP_LOAD   = TIMER_W'(GAP_TICKS);
   localparam logic [TIMER_W-1:0] FLASH_LOAD = TIMER_W'(FLASH_TICKS);
   localparam logic [MISS_W-1:0]  MISS_LIMIT = MISS_W'(MAX_MISSES);

   state_e               state_q, state_d;
   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic [1:0]           idx_q, idx_d;
   logic [N_MOLES-1:0]   mole_led_q, mole_led_d;
   logic                 hit_led_q, hit_led_d;
   logic [SCORE_W-1:0]   score_q, score_d;
   logic [MISS_W-1:0]    miss_cnt_q, miss_cnt_d;
   logic                 game_over_q, game_over_d;

   logic [LFSR_W-1:0]    lfsr_q;
   logic                 lfsr_unused;

   logic                 tick_evt;
   logic                 expire;
   logic                 hit_ok;
   logic                 hit_wrong;
   logic [MISS_W-1:0]    miss_inc;

   lfsr16 u_lfsr (
      .clk   (clk),
      .rst_n (rst_n),
      .seed  (LFSR_SEED),
      .q     (lfsr_q)
   );

   // Only the low two bits pick a mole; the rest just feed the sequence
   assign lfsr_unused = ^lfsr_q[LFSR_W-1:2];

   assign tick_evt  = tick & ~paused;
   assign expire    = tick_evt && (timer_q == TIMER_W'(1));
   assign hit_ok    = ~paused & hit[idx_q];
   assign hit_wrong = ~paused & (hit != '0) & ~hit[idx_q];
   assign miss_inc  = miss_cnt_q + MISS_W'(1);

   // Next-state and output logic
   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      idx_d       = idx_q;
      mole_led_d  = mole_led_q;
      hit_led_d   = hit_led_q;
      score_d     = score_q;
      miss_cnt_d  = miss_cnt_q;
      game_over_d = game_over_q;

      case (state_q)
         ST_IDLE: begin
            mole_led_d  = '0;
            hit_led_d   = 1'b0;
            score_d     = '0;
            miss_cnt_d  = '0;
            game_over_d = 1'b0;
            if (start) begin
               timer_d = GAP_LOAD;
               state_d = ST_GAP;
            end
         end

         ST_GAP: begin
            if (expire) begin
               idx_d      = lfsr_q[1:0];
               mole_led_d = N_MOLES'(1) << lfsr_q[1:0];
               timer_d    = UP_LOAD;
               state_d    = ST_UP;
            end else if (tick_evt) begin
               timer_d = timer_q - TIMER_W'(1);
            end
         end

         ST_UP: begin
            // A correct hit wins over a coincident expiry or wrong bits
            if (hit_ok) begin
               score_d    = (score_q == '1) ? score_q : score_q + SCORE_W'(1);
               mole_led_d = '0;
               hit_led_d  = 1'b1;
               timer_d    = FLASH_LOAD;
               state_d    = ST_FLASH;
            end else if (hit_wrong || expire) begin
               miss_cnt_d = miss_inc;
               mole_led_d = '0;
               if (miss_inc == MISS_LIMIT) begin
                  game_over_d = 1'b1;
                  state_d     = ST_OVER;
               end else begin
                  timer_d = GAP_LOAD;
                  state_d = ST_GAP;
               end
            end else if (tick_evt) begin
               timer_d = timer_q - TIMER_W'(1);
            end
         end

         ST_FLASH: begin
            if (expire) begin
               hit_led_d = 1'b0;
               timer_d   = GAP_LOAD;
               state_d   = ST_GAP;
            end else if (tick_evt) begin
               timer_d = timer_q - TIMER_W'(1);
            end
         end

         ST_OVER: begin
            game_over_d = 1'b1;
            mole_led_d  = '0;
            hit_led_d   = 1'b0;
            if (start) begin
               score_d     = '0;
               miss_cnt_d  = '0;
               game_over_d = 1'b0;
               timer_d     = GAP_LOAD;
               state_d     = ST_GAP;
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         timer_q     <= '0;
         idx_q       <= '0;
         mole_led_q  <= '0;
         hit_led_q   <= 1'b0;
         score_q     <= '0;
         miss_cnt_q  <= '0;
         game_over_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         idx_q       <= idx_d;
         mole_led_q  <= mole_led_d;
         hit_led_q   <= hit_led_d;
         score_q     <= score_d;
         miss_cnt_q  <= miss_cnt_d;
         game_over_q <= game_over_d;
      end
   end

   assign mole_led  = mole_led_q;
   assign hit_led   = hit_led_q;
   assign score     = score_q;
   assign miss_cnt  = miss_cnt_q;
   assign game_over = game_over_q;

endmodule

// File: tb/tb_whack_mole_ctrl.sv
// Directed bench for whack_mole_ctrl with short phase lengths.
module tb_whack_mole_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       tick, start, paused;
   logic [3:0] hit;
   logic [3:0] mole_led;
   logic       hit_led;
   logic [7:0] score;
   logic [3:0] miss_cnt;
   logic       game_over;

   int errors = 0;
   int checks = 0;

   logic [15:0] m_lfsr;
   logic [1:0]  exp_idx = 2'd0;

   always #5 clk = ~clk;

   whack_mole_ctrl #(
      .UP_TICKS    (4),
      .GAP_TICKS   (2),
      .FLASH_TICKS (1),
      .MAX_MISSES  (3),
      .LFSR_SEED   (16'hACE1)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick      (tick),
      .start     (start),
      .paused    (paused),
      .hit       (hit),
      .mole_led  (mole_led),
      .hit_led   (hit_led),
      .score     (score),
      .miss_cnt  (miss_cnt),
      .game_over (game_over)
   );

   // Reference LFSR: x^16+x^14+x^13+x^11+1, right-shifting Galois form
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) m_lfsr <= 16'hACE1;
      else        m_lfsr <= {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
   end

   typedef struct {
      bit       tk;
      bit       st;
      bit       ps;
      bit       latch;    // GAP expires on this vector: capture expected index
      bit [1:0] hsel;     // 0 none, 1 lit key, 2 all keys, 3 one wrong key
      bit       mole_on;
      bit       hl;
      int       sc;
      int       ms;
      bit       ov;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t mk(bit tk, bit st, bit ps, bit latch, bit [1:0] hsel,
                               bit mole_on, bit hl, int sc, int ms, bit ov);
      vec_t v;
      v.tk = tk; v.st = st; v.ps = ps; v.latch = latch; v.hsel = hsel;
      v.mole_on = mole_on; v.hl = hl; v.sc = sc; v.ms = ms; v.ov = ov;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_outs(input string tag, input bit mole_on, input bit hl,
                             input int sc, input int ms, input bit ov);
      logic [3:0] em;
      em = mole_on ? (4'b0001 << exp_idx) : 4'b0000;
      chk({tag, ".mole_led"},  32'(mole_led),  32'(em));
      chk({tag, ".hit_led"},   32'(hit_led),   32'(hl));
      chk({tag, ".score"},     32'(score),     32'(sc));
      chk({tag, ".miss_cnt"},  32'(miss_cnt),  32'(ms));
      chk({tag, ".game_over"}, 32'(game_over), 32'(ov));
   endtask

   // One clock with the given inputs; outputs are examined 1 time unit later
   task automatic cyc(input bit t, input bit s, input bit p, input logic [3:0] h);
      tick = t; start = s; paused = p; hit = h;
      @(posedge clk);
      #1;
      tick = 1'b0; start = 1'b0; hit = 4'b0000;
   endtask

   function automatic logic [3:0] hit_vec(input bit [1:0] hsel);
      logic [1:0] w;
      w = exp_idx + 2'd1;
      case (hsel)
         2'd1:    return 4'b0001 << exp_idx;
         2'd2:    return 4'b1111;
         2'd3:    return 4'b0001 << w;
         default: return 4'b0000;
      endcase
   endfunction

   // Apply one vector; a tick always comes after three quiet clocks
   task automatic apply(input vec_t v);
      if (v.tk) repeat (3) cyc(1'b0, 1'b0, v.ps, 4'b0000);
      if (v.latch) exp_idx = m_lfsr[1:0];
      cyc(v.tk, v.st, v.ps, hit_vec(v.hsel));
   endtask

   task automatic do_tick(input bit p, input bit latch);
      apply(mk(1'b1, 1'b0, p, latch, 2'd0, 1'b0, 1'b0, 0, 0, 1'b0));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      tick = 1'b0; start = 1'b0; paused = 1'b0; hit = 4'b0000;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;
      #1;
      check_outs("reset", 1'b0, 1'b0, 0, 0, 1'b0);

      //          tk st ps lt hs   mo hl sc ms ov
      vt.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0)); // start -> GAP
      vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      vt.push_back(mk(1, 0, 0, 1, 0, 1, 0, 0, 0, 0)); // mole up
      vt.push_back(mk(0, 0, 0, 0, 1, 0, 1, 1, 0, 0)); // correct hit
      vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0)); // flash ends
      vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0));
      vt.push_back(mk(1, 0, 0, 1, 0, 1, 0, 1, 0, 0));
      vt.push_back(mk(0, 0, 0, 0, 2, 0, 1, 2, 0, 0)); // all keys: one point
      vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 2, 0, 0));
      vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 2, 0, 0));
      vt.push_back(mk(1, 0, 0, 1, 0, 1, 0, 2, 0, 0));
      vt.push_back(mk(0, 0, 0, 0, 3, 0, 0, 2, 1, 0)); // wrong key
      vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 2, 1, 0));
      vt.push_back(mk(1, 0, 0, 1, 0, 1, 0, 2, 1, 0));
      vt.push_back(mk(1, 0, 0, 0, 0, 1, 0, 2, 1, 0));
      vt.push_back(mk(1, 0, 0, 0, 0, 1, 0, 2, 1, 0));
      vt.push_back(mk(1, 0, 0, 0, 0, 1, 0, 2, 1, 0));
      vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 2, 2, 0)); // timeout
      vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 2, 2, 0));
      vt.push_back(mk(1, 0, 0, 1, 0, 1, 0, 2, 2, 0));
      vt.push_back(mk(1, 0, 0, 0, 0, 1, 0, 2, 2, 0));
      vt.push_back(mk(1, 0, 0, 0, 0, 1, 0, 2, 2, 0));
      vt.push_back(mk(1, 0, 0, 0, 0, 1, 0, 2, 2, 0));
      vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 2, 3, 1)); // third miss -> OVER
      vt.push_back(mk(0, 0, 0, 0, 1, 0, 0, 2, 3, 1)); // hit ignored in OVER
      vt.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0)); // restart clears
      vt.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0)); // start ignored in GAP
      vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      vt.push_back(mk(1, 0, 0, 1, 0, 1, 0, 0, 0, 0));
      vt.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      vt.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      vt.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
      vt.push_back(mk(1, 0, 0, 0, 1, 0, 1, 1, 0, 0)); // hit on final tick
      vt.push_back(mk(0, 0, 0, 0, 1, 0, 1, 1, 0, 0)); // hit ignored in FLASH
      vt.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0)); // back to GAP

      for (int i = 0; i < vt.size(); i++) begin
         apply(vt[i]);
         check_outs($sformatf("vec%0d", i), vt[i].mole_on, vt[i].hl,
                    vt[i].sc, vt[i].ms, vt[i].ov);
      end

      // Pause mid-UP: one tick counted, 20 frozen ticks, then three more
      do_tick(1'b0, 1'b0);
      do_tick(1'b0, 1'b1);
      check_outs("pause.up", 1'b1, 1'b0, 1, 0, 1'b0);
      do_tick(1'b0, 1'b0);
      for (int i = 0; i < 20; i++) begin
         do_tick(1'b1, 1'b0);
         if (i == 10) cyc(1'b0, 1'b0, 1'b1, 4'b0001 << exp_idx);
      end
      check_outs("pause.frozen", 1'b1, 1'b0, 1, 0, 1'b0);
      do_tick(1'b0, 1'b0);
      do_tick(1'b0, 1'b0);
      check_outs("pause.tick3", 1'b1, 1'b0, 1, 0, 1'b0);
      do_tick(1'b0, 1'b0);
      check_outs("pause.expire", 1'b0, 1'b0, 1, 1, 1'b0);

      // Reset while in FLASH
      do_tick(1'b0, 1'b0);
      do_tick(1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 4'b0001 << exp_idx);
      check_outs("flash.enter", 1'b0, 1'b1, 2, 1, 1'b0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_outs("async_reset", 1'b0, 1'b0, 0, 0, 1'b0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_outs("post_reset", 1'b0, 1'b0, 0, 0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 4'b1111);
      check_outs("idle_hit", 1'b0, 1'b0, 0, 0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 4'b0000);
      do_tick(1'b0, 1'b0);
      check_outs("restart.gap", 1'b0, 1'b0, 0, 0, 1'b0);
      do_tick(1'b0, 1'b1);
      check_outs("restart.up", 1'b1, 1'b0, 0, 0, 1'b0);

      // Score saturation: 255 hits, then one more
      cyc(1'b0, 1'b0, 1'b0, 4'b0001 << exp_idx);
      do_tick(1'b0, 1'b0);
      for (int i = 1; i < 255; i++) begin
         do_tick(1'b0, 1'b0);
         do_tick(1'b0, 1'b1);
         cyc(1'b0, 1'b0, 1'b0, 4'b0001 << exp_idx);
         do_tick(1'b0, 1'b0);
      end
      check_outs("sat.255", 1'b0, 1'b0, 255, 0, 1'b0);
      do_tick(1'b0, 1'b0);
      do_tick(1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 4'b0001 << exp_idx);
      check_outs("sat.hold", 1'b0, 1'b1, 255, 0, 1'b0);
      do_tick(1'b0, 1'b0);
      check_outs("sat.gap", 1'b0, 1'b0, 255, 0, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
